// File: rtl/cache_bus_arbiter_pkg.sv
// Shared encodings for cache_bus_arbiter: FSM states, owner codes and default bus size.
package cache_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b11,
        ST_DONE = 2'b10
    } arb_state_t;

    localparam logic       OWN_INST      = 1'b0;
    localparam logic       OWN_DATA      = 1'b1;
    localparam logic [1:0] WORD_SIZE_DEF = 2'd2;

endpackage

// File: rtl/cache_bus_arbiter_grant.sv
// cache_arb_grant: picks which cache owns the next bus transfer.
// CACHE_ARB_RR_EN selects round-robin on contention; otherwise data beats inst.
module cache_arb_grant
    import cache_bus_arbiter_pkg::*;
(
    input  logic i_inst_req,
    input  logic i_data_req,
`ifdef CACHE_ARB_RR_EN
    input  logic i_last_owner,
`endif
    output logic o_valid,
    output logic o_owner
);

    always_comb begin
        o_valid = i_inst_req | i_data_req;
`ifdef CACHE_ARB_RR_EN
        if (i_inst_req && i_data_req) begin
            o_owner = (i_last_owner == OWN_INST) ? OWN_DATA : OWN_INST;
        end else begin
            o_owner = i_data_req ? OWN_DATA : OWN_INST;
        end
`else
        o_owner = i_data_req ? OWN_DATA : OWN_INST;
`endif
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: serves single-word I$/D$ requests one at a time over the SRAM-like bus.
// Optional CACHE_ARB_RR_EN: round-robin grant with a last_owner register.
//
// state | meaning
// IDLE  | sample both requests, latch the winner's addr/wr/wdata
// ADDR  | bus_req high until bus_addr_ok
// DATA  | wait for bus_data_ok, capture read data
// DONE  | one-cycle dok to the owner, then back to IDLE
module cache_bus_arbiter
    import cache_bus_arbiter_pkg::*;
#(
    parameter logic [1:0] WORD_SIZE = WORD_SIZE_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_cache_req,
    input  logic [31:0] inst_cache_addr,
    output logic [31:0] inst_cache_rdata,
    output logic        inst_cache_dok,
    input  logic        data_cache_req,
    input  logic        data_cache_wr,
    input  logic [31:0] data_cache_addr,
    input  logic [31:0] data_cache_wdata,
    output logic [31:0] data_cache_rdata,
    output logic        data_cache_dok,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    logic        r_owner;
    logic        r_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;
    logic        w_grant_valid;
    logic        w_grant_owner;
    logic        w_grant;
    logic        w_capture;

`ifdef CACHE_ARB_RR_EN
    logic r_last_owner;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_owner <= OWN_INST;
        end else if (w_grant) begin
            r_last_owner <= w_grant_owner;
        end
    end
`endif

    cache_arb_grant u_grant (
        .i_inst_req   (inst_cache_req),
        .i_data_req   (data_cache_req),
`ifdef CACHE_ARB_RR_EN
        .i_last_owner (r_last_owner),
`endif
        .o_valid      (w_grant_valid),
        .o_owner      (w_grant_owner)
    );

    assign w_grant = (r_state == ST_IDLE) && w_grant_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                // a slave may finish the whole transfer in the address cycle
                if (bus_addr_ok && bus_data_ok) begin
                    w_state_nxt = ST_DONE;
                    w_capture   = 1'b1;
                end else if (bus_addr_ok) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    w_state_nxt = ST_DONE;
                    w_capture   = 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner      <= OWN_INST;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_owner <= w_grant_owner;
                if (w_grant_owner == OWN_DATA) begin
                    r_wr    <= data_cache_wr;
                    r_addr  <= data_cache_addr;
                    r_wdata <= data_cache_wdata;
                end else begin
                    r_wr    <= 1'b0;
                    r_addr  <= inst_cache_addr;
                    r_wdata <= '0;
                end
            end
            if (w_capture) begin
                if (r_owner == OWN_INST) begin
                    r_inst_rdata <= bus_rdata;
                end else if (!r_wr) begin
                    r_data_rdata <= bus_rdata;
                end
            end
        end
    end

    assign bus_req          = (r_state == ST_ADDR);
    assign bus_wr           = r_wr;
    assign bus_size         = WORD_SIZE;
    assign bus_addr         = r_addr;
    assign bus_wdata        = r_wdata;
    assign inst_cache_dok   = (r_state == ST_DONE) && (r_owner == OWN_INST);
    assign data_cache_dok   = (r_state == ST_DONE) && (r_owner == OWN_DATA);
    assign inst_cache_rdata = r_inst_rdata;
    assign data_cache_rdata = r_data_rdata;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: directed vector table, hand sequences
// and randomized transactions against a memory-level reference model.
`timescale 1ns/1ps
module tb_cache_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_cache_req = 1'b0;
    logic [31:0] inst_cache_addr = '0;
    logic [31:0] inst_cache_rdata;
    logic        inst_cache_dok;
    logic        data_cache_req = 1'b0;
    logic        data_cache_wr = 1'b0;
    logic [31:0] data_cache_addr = '0;
    logic [31:0] data_cache_wdata = '0;
    logic [31:0] data_cache_rdata;
    logic        data_cache_dok;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;

    always #5 clk = ~clk;

    cache_bus_arbiter dut (
        .clk              (clk),
        .resetn           (resetn),
        .inst_cache_req   (inst_cache_req),
        .inst_cache_addr  (inst_cache_addr),
        .inst_cache_rdata (inst_cache_rdata),
        .inst_cache_dok   (inst_cache_dok),
        .data_cache_req   (data_cache_req),
        .data_cache_wr    (data_cache_wr),
        .data_cache_addr  (data_cache_addr),
        .data_cache_wdata (data_cache_wdata),
        .data_cache_rdata (data_cache_rdata),
        .data_cache_dok   (data_cache_dok),
        .bus_req          (bus_req),
        .bus_wr           (bus_wr),
        .bus_size         (bus_size),
        .bus_addr         (bus_addr),
        .bus_wdata        (bus_wdata),
        .bus_addr_ok      (bus_addr_ok),
        .bus_data_ok      (bus_data_ok),
        .bus_rdata        (bus_rdata)
    );

    int checks = 0;
    int failures = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // initial memory image seen by both the bus slave and the reference model
    function automatic logic [31:0] init_val(input logic [31:0] a);
        if (a == 32'h1FAF_0010) return 32'hDEAD_BEEF;
        if (a == 32'hBFC0_0000) return 32'h3C08_BFC0;
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h0F0F};
    endfunction

    // ---------------- bus slave (memory behind the SRAM-like bus) ----------------
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } bus_rec_t;

    bus_rec_t    bus_log[$];
    logic [31:0] slv_mem [logic [31:0]];
    int          cfg_adly = 0;
    int          cfg_ddly = 0;
    bit          cfg_same = 1'b0;
    bit          cfg_noise = 1'b0;
    int          req_cycles = 0;
    int          sl_ph = 0;
    int          sl_cnt = 0;
    bus_rec_t    sl_cur;

    task automatic slave_complete();
        if (sl_cur.wr) begin
            slv_mem[sl_cur.addr] = sl_cur.wdata;
        end else begin
            bus_rdata = slv_mem.exists(sl_cur.addr) ? slv_mem[sl_cur.addr] : init_val(sl_cur.addr);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = $urandom;
        if (!resetn) begin
            sl_ph = 0;
        end else begin
            if (bus_req) req_cycles++;
            if (sl_ph == 0 && bus_req) begin
                sl_ph  = 1;
                sl_cnt = 0;
            end
            if (sl_ph == 1) begin
                if (sl_cnt == cfg_adly) begin
                    bus_addr_ok = 1'b1;
                    sl_cur = '{bus_addr, bus_wr, bus_wdata};
                    bus_log.push_back(sl_cur);
                    if (cfg_same) begin
                        bus_data_ok = 1'b1;
                        slave_complete();
                        sl_ph = 0;
                    end else begin
                        sl_ph  = 2;
                        sl_cnt = 0;
                    end
                end else begin
                    sl_cnt++;
                    if (cfg_noise) bus_data_ok = 1'($urandom_range(0, 1));
                end
            end else if (sl_ph == 2) begin
                if (sl_cnt == cfg_ddly) begin
                    bus_data_ok = 1'b1;
                    slave_complete();
                    sl_ph = 0;
                end else begin
                    sl_cnt++;
                    if (cfg_noise) bus_addr_ok = 1'($urandom_range(0, 1));
                end
            end else if (cfg_noise) begin
                bus_addr_ok = 1'($urandom_range(0, 1));
                bus_data_ok = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] m_inst_rd = '0;
    logic [31:0] m_data_rd = '0;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic int model_latency(input int adly, input int ddly, input bit same);
        return same ? 2 + adly : 3 + adly + ddly;
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        inst_cache_req = 1'b0;
        data_cache_req = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        m_inst_rd = '0;
        m_data_rd = '0;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string pfx);
        check32({pfx, "_bus_req"}, 32'(bus_req), 32'h0);
        check32({pfx, "_bus_wr"}, 32'(bus_wr), 32'h0);
        check32({pfx, "_bus_addr"}, bus_addr, 32'h0);
        check32({pfx, "_bus_wdata"}, bus_wdata, 32'h0);
        check32({pfx, "_inst_dok"}, 32'(inst_cache_dok), 32'h0);
        check32({pfx, "_data_dok"}, 32'(data_cache_dok), 32'h0);
        check32({pfx, "_inst_rdata"}, inst_cache_rdata, 32'h0);
        check32({pfx, "_data_rdata"}, data_cache_rdata, 32'h0);
    endtask

    // Called just after a negedge with the DUT idle; returns after the negedge following dok.
    task automatic run_txn(input string name, input bit is_data, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_rdata,
                           input bit scramble);
        int       lat;
        int       base;
        int       req_base;
        bit       other_dok;
        bus_rec_t rec;
        lat = 0;
        other_dok = 1'b0;
        base = bus_log.size();
        req_base = req_cycles;
        if (is_data) begin
            data_cache_req   = 1'b1;
            data_cache_wr    = wr;
            data_cache_addr  = addr;
            data_cache_wdata = wdata;
        end else begin
            inst_cache_req  = 1'b1;
            inst_cache_addr = addr;
        end
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (scramble && c == 1) begin
                inst_cache_addr  = $urandom;
                data_cache_addr  = $urandom;
                data_cache_wdata = $urandom;
                data_cache_wr    = ~data_cache_wr;
            end
            if (is_data ? inst_cache_dok : data_cache_dok) other_dok = 1'b1;
            if (is_data ? data_cache_dok : inst_cache_dok) begin
                lat = c;
                break;
            end
        end
        check_int({name, "_latency"}, lat, exp_lat);
        if (lat == 0) begin
            do_reset();
            return;
        end
        check32({name, "_rdata"}, is_data ? data_cache_rdata : inst_cache_rdata, exp_rdata);
        check32({name, "_other_rdata"}, is_data ? inst_cache_rdata : data_cache_rdata,
                is_data ? m_inst_rd : m_data_rd);
        check_int({name, "_other_dok"}, int'(other_dok), 0);
        check_int({name, "_bus_txns"}, bus_log.size() - base, 1);
        if (bus_log.size() > base) begin
            rec = bus_log[base];
            check32({name, "_bus_addr"}, rec.addr, addr);
            check_int({name, "_bus_wr"}, int'(rec.wr), int'(is_data & wr));
            if (is_data && wr) check32({name, "_bus_wdata"}, rec.wdata, wdata);
        end
        check_int({name, "_req_cycles"}, req_cycles - req_base, cfg_adly + 1);
        inst_cache_req = 1'b0;
        data_cache_req = 1'b0;
        if (is_data) m_data_rd = exp_rdata;
        else         m_inst_rd = exp_rdata;
        if (is_data && wr) ref_mem[addr] = wdata;
        @(negedge clk);
        check_int({name, "_dok_pulse"}, int'(inst_cache_dok | data_cache_dok), 0);
    endtask

    typedef struct {
        string       name;
        bit          is_data;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          adly;
        int          ddly;
        bit          same;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   d_cyc;
        int   i_cyc;
        int   base;
        int   lat1;
        int   lat2;

        vecs[0] = '{"dread_1faf", 1'b1, 1'b0, 32'h1FAF_0010, 32'h0, 0, 0, 1'b0, 3, 32'hDEAD_BEEF};
        vecs[1] = '{"dwrite_400", 1'b1, 1'b1, 32'h0000_0400, 32'h1234_5678, 4, 0, 1'b0, 7, 32'hDEAD_BEEF};
        vecs[2] = '{"dread_400", 1'b1, 1'b0, 32'h0000_0400, 32'h0, 0, 2, 1'b0, 5, 32'h1234_5678};
        vecs[3] = '{"iread_400_same", 1'b0, 1'b0, 32'h0000_0400, 32'h0, 1, 0, 1'b1, 3, 32'h1234_5678};
        vecs[4] = '{"dread_same", 1'b1, 1'b0, 32'h1FAF_0010, 32'h0, 0, 0, 1'b1, 2, 32'hDEAD_BEEF};
        vecs[5] = '{"iread_bfc", 1'b0, 1'b0, 32'hBFC0_0000, 32'h0, 2, 1, 1'b0, 6, 32'h3C08_BFC0};

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check32("reset_bus_size", 32'(bus_size), 32'h2);
        resetn = 1'b1;
        @(negedge clk);

        // directed vectors
        for (int i = 0; i < 6; i++) begin
            cfg_adly = vecs[i].adly;
            cfg_ddly = vecs[i].ddly;
            cfg_same = vecs[i].same;
            cfg_noise = 1'b0;
            run_txn(vecs[i].name, vecs[i].is_data, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_lat, vecs[i].exp_rdata, 1'b0);
        end

        // simultaneous requests, both held: data first, inst right after one IDLE cycle
        do_reset();
        cfg_adly = 0; cfg_ddly = 0; cfg_same = 1'b0; cfg_noise = 1'b0;
        base = bus_log.size();
        d_cyc = 0; i_cyc = 0;
        inst_cache_req = 1'b1; inst_cache_addr = 32'h0000_0040;
        data_cache_req = 1'b1; data_cache_wr = 1'b0; data_cache_addr = 32'h0000_0080;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (data_cache_dok && d_cyc == 0) begin
                d_cyc = c;
                data_cache_req = 1'b0;
                check32("both_data_rdata", data_cache_rdata, model_read(32'h0000_0080));
            end
            if (inst_cache_dok && i_cyc == 0) begin
                i_cyc = c;
                inst_cache_req = 1'b0;
                check32("both_inst_rdata", inst_cache_rdata, model_read(32'h0000_0040));
            end
            if (d_cyc != 0 && i_cyc != 0) break;
        end
        check_int("both_data_dok_cycle", d_cyc, 3);
        check_int("both_inst_dok_cycle", i_cyc, 7);
        check_int("both_bus_txns", bus_log.size() - base, 2);
        if (bus_log.size() >= base + 2) begin
            check32("both_first_addr", bus_log[base].addr, 32'h0000_0080);
            check32("both_second_addr", bus_log[base + 1].addr, 32'h0000_0040);
        end
        inst_cache_req = 1'b0; data_cache_req = 1'b0;
        m_data_rd = model_read(32'h0000_0080);
        m_inst_rd = model_read(32'h0000_0040);
        @(negedge clk);

        // write-back then load with req held high
        base = bus_log.size();
        lat1 = 0; lat2 = 0;
        data_cache_req = 1'b1; data_cache_wr = 1'b1;
        data_cache_addr = 32'h0000_0100; data_cache_wdata = 32'hCAFE_F00D;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (data_cache_dok && lat1 == 0) begin
                lat1 = c;
                check32("wb_write_rdata_hold", data_cache_rdata, m_data_rd);
                data_cache_addr = 32'h0000_0200;
                data_cache_wr   = 1'b0;
            end else if (data_cache_dok && lat1 != 0) begin
                lat2 = c - lat1;
                check32("wb_load_rdata", data_cache_rdata, model_read(32'h0000_0200));
                break;
            end
        end
        data_cache_req = 1'b0;
        ref_mem[32'h0000_0100] = 32'hCAFE_F00D;
        m_data_rd = model_read(32'h0000_0200);
        check_int("wb_first_latency", lat1, 3);
        check_int("wb_second_latency", lat2, 4);
        check_int("wb_bus_txns", bus_log.size() - base, 2);
        if (bus_log.size() >= base + 2) begin
            check32("wb_first_addr", bus_log[base].addr, 32'h0000_0100);
            check_int("wb_first_wr", int'(bus_log[base].wr), 1);
            check32("wb_first_wdata", bus_log[base].wdata, 32'hCAFE_F00D);
            check32("wb_second_addr", bus_log[base + 1].addr, 32'h0000_0200);
            check_int("wb_second_wr", int'(bus_log[base + 1].wr), 0);
        end
        @(negedge clk);

        // randomized transactions with bus noise and input scrambling after grant
        for (int n = 0; n < 40; n++) begin
            bit          r_is_data;
            bit          r_wr;
            logic [31:0] r_addr;
            logic [31:0] r_wdata;
            logic [31:0] r_exp;
            r_is_data = 1'($urandom_range(0, 1));
            r_wr      = r_is_data ? 1'($urandom_range(0, 1)) : 1'b0;
            r_addr    = 32'h0000_1000 + 32'($urandom_range(0, 7)) * 4;
            r_wdata   = $urandom;
            cfg_adly  = $urandom_range(0, 3);
            cfg_ddly  = $urandom_range(0, 3);
            cfg_same  = ($urandom_range(0, 3) == 0);
            cfg_noise = 1'b1;
            r_exp     = (r_is_data && r_wr) ? m_data_rd : model_read(r_addr);
            run_txn($sformatf("rand%0d", n), r_is_data, r_wr, r_addr, r_wdata,
                    model_latency(cfg_adly, cfg_ddly, cfg_same), r_exp, 1'b1);
        end
        cfg_noise = 1'b0;

        // reset asserted mid-DATA, then a normal inst fetch
        cfg_adly = 0; cfg_ddly = 6; cfg_same = 1'b0;
        data_cache_req = 1'b1; data_cache_wr = 1'b1;
        data_cache_addr = 32'h0000_0300; data_cache_wdata = 32'h55AA_33CC;
        repeat (2) @(negedge clk);
        check_int("rst_pre_bus_wr", int'(bus_wr), 1);
        check32("rst_pre_bus_wdata", bus_wdata, 32'h55AA_33CC);
        #2 resetn = 1'b0;
        #1 check_all_zero("rst_mid");
        data_cache_req = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        m_inst_rd = '0;
        m_data_rd = '0;
        @(negedge clk);
        cfg_ddly = 0;
        run_txn("post_rst_iread", 1'b0, 1'b0, 32'hBFC0_0000, 32'h0, 3, 32'h3C08_BFC0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
